debug_unit: RTL and testbench
=============================

// Module: debug_unit
// PURPOSE
//  Host-side controller for the pipeline debug port. Decodes a UART byte stream into commands.
//  Drives: instruction-memory load, PC reset and clock enable (continuous or single step).
//  On stop it reads back the 32 registers plus N_MEM_WORDS data-memory words and streams them as bytes to UART TX.
//  Sits between the uart rx/tx blocks and the pipeline top.
// PARAMETERS
//  NB_REG      32  data/instruction word width
//  NB_WIDHT    9   data-memory byte-address width
//  NB_ADDR     5   register-file address width
//  NB_BYTE     8   UART byte width
//  N_MEM_WORDS 32  data-memory words dumped (word k at byte address 4k)
//  RD_LAT      2   cycles from address change to readback capture
// PORTS
//  i_clk             in   1        system clock
//  i_reset           in   1        asynchronous, active-low reset
//  i_rx_data         in   8        received byte
//  i_rx_valid        in   1        1-cycle pulse per received byte
//  o_tx_data         out  8        byte to transmit
//  o_tx_valid        out  1        byte valid; held until i_tx_ready
//  i_tx_ready        in   1        TX accepts byte when valid&ready
//  i_halt            in   1        pipeline halt reached WB
//  i_dunit_reg       in   32       register-file readback
//  i_dunit_mem_data  in   32       data-memory readback
//  o_dunit_clk_en    out  1        pipeline clock enable
//  o_dunit_reset_pc  out  1        PC reset pulse
//  o_dunit_w_mem     out  1        instruction-memory write strobe
//  o_dunit_mem_addr  out  32       instruction-memory byte address
//  o_dunit_data_if   out  32       instruction word to write
//  o_dunit_addr      out  5        register readback address
//  o_dunit_addr_data out  9        data-memory readback byte address
//  o_state           out  4        current FSM state (for LEDs)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE. Reset mid-operation aborts any load, run or dump; no partial byte is resent.
//  IDLE: decode i_rx_data on i_rx_valid. Unknown bytes are ignored.
//   'L'(0x4C)->LOAD_LEN; 'R'(0x52)->RST_PC; 'S'(0x53)->STEP; 'C'(0x43)->RUN.
//  LOAD_LEN: next byte N = word count. N=0 -> back to IDLE, no writes.
//  LOAD_BYTE: assembles 4 bytes MSB-first into one word.
//  LOAD_WRITE: for word i, o_dunit_mem_addr=4*i and o_dunit_data_if=word, with o_dunit_w_mem high for exactly 1 cycle.
//   After N words -> IDLE. clk_en stays 0 throughout the load.
//  RST_PC: o_dunit_reset_pc high for 1 cycle -> IDLE.
//  STEP: o_dunit_clk_en high for exactly 1 cycle -> DUMP.
//  RUN: clk_en held high until i_halt is sampled 1; clk_en drops the next cycle -> DUMP.
//  S or C while i_halt already 1: clk_en is never raised; go straight to DUMP.
//  DUMP reads 32 registers (addr 0..31), then N_MEM_WORDS memory words (o_dunit_addr_data=4k, wraps mod 2^NB_WIDHT).
//   Per word: DUMP_ADDR sets the address, DUMP_WAIT waits RD_LAT cycles, capture, then DUMP_SEND sends 4 bytes MSB-first.
//   Each byte uses valid/ready: o_tx_data is stable while o_tx_valid=1 && !i_tx_ready.
//   After the last byte -> IDLE.
//  RX bytes arriving outside IDLE/LOAD_* are dropped.
//  A dump is exactly 4*(32+N_MEM_WORDS) bytes. clk_en is 0 for the whole dump.
//  Load word counter is 8-bit. The address is computed as {counter,2'b00} zero-extended to 32 bits.
// STRUCTURE
//  debug_unit_pkg.vh: command byte localparams, FSM state encodings, DUMP_BYTES.
//  Sub-module word_serializer: takes a 32-bit word with load pulse and emits 4 bytes MSB-first over valid/ready.
//   Its done pulse advances the dump FSM.
//  Top FSM, load assembler and counters stay in debug_unit.
// TESTING
//  1. 'L',0x02,11 22 33 44,AA BB CC DD -> w_mem pulses at addr 0 data 0x11223344, then addr 4 data 0xAABBCCDD; clk_en stays 0.
//  2. 'S' with i_halt=0 -> clk_en=1 for 1 cycle.
//   Then 256 TX bytes (N_MEM_WORDS=32): regs 0..31 then mem 0..124. Register model r=0x100+a yields first bytes 00 00 01 00.
//  3. 'C', i_halt asserted 10 cycles later -> clk_en high for exactly 10 cycles, then full dump.
//   A second 'C' with halt still 1 -> dump with no clk_en.
//  4. i_tx_ready held low 5 cycles mid-dump -> o_tx_data/o_tx_valid stable; no byte lost or duplicated.
//  5. 'R' -> reset_pc single-cycle pulse. 0x7F and 'L',0x00 -> no outputs change, FSM back in IDLE.
//  6. i_reset low during RUN and during DUMP -> clk_en=0, tx_valid=0 immediately; FSM=IDLE after release.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// rtl/debug_unit_pkg.sv - command bytes, FSM encodings and dump sizing for the debug unit
package debug_unit_pkg;

    localparam logic [7:0] CMD_LOAD   = 8'h4C;
    localparam logic [7:0] CMD_RST_PC = 8'h52;
    localparam logic [7:0] CMD_STEP   = 8'h53;
    localparam logic [7:0] CMD_RUN    = 8'h43;

    localparam int NUM_REGS       = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int DUMP_MEM_WORDS = 32;
    localparam int DUMP_BYTES     = BYTES_PER_WORD * (NUM_REGS + DUMP_MEM_WORDS);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LOAD_LEN   = 4'd1,
        ST_LOAD_BYTE  = 4'd2,
        ST_LOAD_WRITE = 4'd3,
        ST_RST_PC     = 4'd4,
        ST_STEP       = 4'd5,
        ST_RUN        = 4'd6,
        ST_DUMP_ADDR  = 4'd7,
        ST_DUMP_WAIT  = 4'd8,
        ST_DUMP_SEND  = 4'd9
    } state_t;

endpackage

// File: rtl/debug_unit_word_serializer.sv
// rtl/debug_unit_word_serializer.sv - splits one word into bytes, MSB first, over valid/ready
module debug_unit_word_serializer #(
    parameter int NB_WORD = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_WORD-1:0] i_word,
    input  logic               i_load,
    output logic [NB_BYTE-1:0] o_tdata,
    output logic               o_tvalid,
    input  logic               i_tready,
    output logic               o_done
);

    localparam int N_BYTES = NB_WORD / NB_BYTE;
    localparam int CW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [NB_WORD-1:0] r_shift;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               w_accept;
    logic               w_last;

    assign w_accept = r_busy && i_tready;
    assign w_last   = (r_cnt == CW'(N_BYTES - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_accept && w_last;
            if (i_load) begin
                r_shift <= i_word;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (w_accept) begin
                r_shift <= {r_shift[NB_WORD-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    // Top byte of the shift register is the one on the wire; it only moves on acceptance.
    assign o_tdata  = r_shift[NB_WORD-1 -: NB_BYTE];
    assign o_tvalid = r_busy;
    assign o_done   = r_done;

endmodule

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - UART command decoder, program loader, run control and state dump
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_WIDHT    = 9,
    parameter int NB_ADDR     = 5,
    parameter int NB_BYTE     = 8,
    parameter int N_MEM_WORDS = DUMP_BYTES / BYTES_PER_WORD - NUM_REGS,
    parameter int RD_LAT      = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_BYTE-1:0]  o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    input  logic                i_halt,
    input  logic [NB_REG-1:0]   i_dunit_reg,
    input  logic [NB_REG-1:0]   i_dunit_mem_data,
    output logic                o_dunit_clk_en,
    output logic                o_dunit_reset_pc,
    output logic                o_dunit_w_mem,
    output logic [NB_REG-1:0]   o_dunit_mem_addr,
    output logic [NB_REG-1:0]   o_dunit_data_if,
    output logic [NB_ADDR-1:0]  o_dunit_addr,
    output logic [NB_WIDHT-1:0] o_dunit_addr_data,
    output logic [3:0]          o_state
);

    localparam int N_WORDS = NUM_REGS + N_MEM_WORDS;
    localparam int IW      = $clog2(N_WORDS);
    localparam int WW      = $clog2(RD_LAT + 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [7:0]                 r_len;
    logic [7:0]                 r_word_cnt;
    logic [1:0]                 r_byte_cnt;
    logic [NB_REG-NB_BYTE-1:0]  r_asm;
    logic [NB_REG-1:0]          r_mem_addr;
    logic [NB_REG-1:0]          r_data_if;
    logic [IW-1:0]              r_dump_idx;
    logic [WW-1:0]              r_wait;
    logic [NB_ADDR-1:0]         r_reg_addr;
    logic [NB_WIDHT-1:0]        r_mem_rd_addr;

    logic [NB_REG-1:0]          w_asm_next;
    logic [IW-1:0]              w_mem_k;
    logic                       w_is_reg;
    logic                       w_last_load;
    logic                       w_last_word;
    logic [NB_REG-1:0]          w_ser_word;
    logic                       w_ser_load;
    logic                       w_ser_done;
    logic                       w_clk_en;
    logic                       w_reset_pc;
    logic                       w_w_mem;

    assign w_asm_next  = {r_asm, i_rx_data};
    assign w_is_reg    = (r_dump_idx < IW'(NUM_REGS));
    assign w_mem_k     = r_dump_idx - IW'(NUM_REGS);
    assign w_last_load = (r_word_cnt == r_len - 8'd1);
    assign w_last_word = (r_dump_idx == IW'(N_WORDS - 1));
    assign w_ser_word  = w_is_reg ? i_dunit_reg : i_dunit_mem_data;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clk_en   = 1'b0;
        w_reset_pc = 1'b0;
        w_w_mem    = 1'b0;
        w_ser_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD:   w_next = ST_LOAD_LEN;
                        CMD_RST_PC: w_next = ST_RST_PC;
                        CMD_STEP:   w_next = i_halt ? ST_DUMP_ADDR : ST_STEP;
                        CMD_RUN:    w_next = i_halt ? ST_DUMP_ADDR : ST_RUN;
                        default:    w_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD_LEN: begin
                if (i_rx_valid) begin
                    w_next = (i_rx_data == '0) ? ST_IDLE : ST_LOAD_BYTE;
                end
            end
            ST_LOAD_BYTE: begin
                if (i_rx_valid && r_byte_cnt == 2'd3) begin
                    w_next = ST_LOAD_WRITE;
                end
            end
            ST_LOAD_WRITE: begin
                w_w_mem = 1'b1;
                w_next  = w_last_load ? ST_IDLE : ST_LOAD_BYTE;
            end
            ST_RST_PC: begin
                w_reset_pc = 1'b1;
                w_next     = ST_IDLE;
            end
            ST_STEP: begin
                w_clk_en = 1'b1;
                w_next   = ST_DUMP_ADDR;
            end
            ST_RUN: begin
                w_clk_en = 1'b1;
                if (i_halt) begin
                    w_next = ST_DUMP_ADDR;
                end
            end
            ST_DUMP_ADDR: w_next = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                if (r_wait == WW'(RD_LAT - 1)) begin
                    w_ser_load = 1'b1;
                    w_next     = ST_DUMP_SEND;
                end
            end
            ST_DUMP_SEND: begin
                if (w_ser_done) begin
                    w_next = w_last_word ? ST_IDLE : ST_DUMP_ADDR;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_len         <= '0;
            r_word_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_asm         <= '0;
            r_mem_addr    <= '0;
            r_data_if     <= '0;
            r_dump_idx    <= '0;
            r_wait        <= '0;
            r_reg_addr    <= '0;
            r_mem_rd_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_dump_idx <= '0;
                ST_LOAD_LEN: begin
                    if (i_rx_valid) begin
                        r_len      <= i_rx_data;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                ST_LOAD_BYTE: begin
                    if (i_rx_valid) begin
                        r_asm      <= w_asm_next[NB_REG-NB_BYTE-1:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Address and data are latched together so the write strobe sees a stable pair.
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_addr <= NB_REG'({r_word_cnt, 2'b00});
                            r_data_if  <= w_asm_next;
                        end
                    end
                end
                ST_LOAD_WRITE: r_word_cnt <= r_word_cnt + 8'd1;
                ST_DUMP_ADDR: begin
                    if (w_is_reg) begin
                        r_reg_addr <= r_dump_idx[NB_ADDR-1:0];
                    end else begin
                        r_mem_rd_addr <= NB_WIDHT'({w_mem_k, 2'b00});
                    end
                    r_wait <= '0;
                end
                ST_DUMP_WAIT: r_wait <= r_wait + WW'(1);
                ST_DUMP_SEND: begin
                    if (w_ser_done) begin
                        r_dump_idx <= r_dump_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    debug_unit_word_serializer #(
        .NB_WORD (NB_REG),
        .NB_BYTE (NB_BYTE)
    ) u_serializer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_word   (w_ser_word),
        .i_load   (w_ser_load),
        .o_tdata  (o_tx_data),
        .o_tvalid (o_tx_valid),
        .i_tready (i_tx_ready),
        .o_done   (w_ser_done)
    );

    assign o_dunit_clk_en    = w_clk_en;
    assign o_dunit_reset_pc  = w_reset_pc;
    assign o_dunit_w_mem     = w_w_mem;
    assign o_dunit_mem_addr  = r_mem_addr;
    assign o_dunit_data_if   = r_data_if;
    assign o_dunit_addr      = r_reg_addr;
    assign o_dunit_addr_data = r_mem_rd_addr;
    assign o_state           = r_state;

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - self-checking bench for debug_unit
module tb_debug_unit;
    import debug_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [31:0] dunit_reg;
    logic [31:0] dunit_mem_data;
    logic        clk_en;
    logic        reset_pc;
    logic        w_mem;
    logic [31:0] mem_addr;
    logic [31:0] data_if;
    logic [4:0]  rd_addr;
    logic [8:0]  rd_addr_data;
    logic [3:0]  state;

    int n_pass = 0;
    int n_total = 0;
    int tx_cnt = 0;
    int w_cnt = 0;
    int clk_en_cnt = 0;
    int rst_pc_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_w = 1'b0;
    logic [7:0]  tx_q[$];
    logic [63:0] w_q[$];

    always #5 clk = ~clk;

    debug_unit dut (
        .i_clk             (clk),
        .i_reset           (rst_n),
        .i_rx_data         (rx_data),
        .i_rx_valid        (rx_valid),
        .o_tx_data         (tx_data),
        .o_tx_valid        (tx_valid),
        .i_tx_ready        (tx_ready),
        .i_halt            (halt),
        .i_dunit_reg       (dunit_reg),
        .i_dunit_mem_data  (dunit_mem_data),
        .o_dunit_clk_en    (clk_en),
        .o_dunit_reset_pc  (reset_pc),
        .o_dunit_w_mem     (w_mem),
        .o_dunit_mem_addr  (mem_addr),
        .o_dunit_data_if   (data_if),
        .o_dunit_addr      (rd_addr),
        .o_dunit_addr_data (rd_addr_data),
        .o_state           (state)
    );

    // Synchronous-read models: data follows the address one clock later.
    always @(posedge clk) begin
        dunit_reg      <= 32'h0000_0100 + 32'(rd_addr);
        dunit_mem_data <= 32'hC0DE_0000 + 32'(rd_addr_data);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_w     = 1'b0;
        end else begin
            if (prev_stall) check("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, prev_data}));
            if (tx_valid) check("clk_en_in_dump", 64'(clk_en), 64'(0));
            if (tx_valid && tx_ready) begin
                tx_cnt++;
                check("tx_queue_nonempty", 64'(tx_q.size() != 0), 64'(1));
                if (tx_q.size() != 0) check("tx_byte", 64'(tx_data), 64'(tx_q.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (w_mem) begin
                w_cnt++;
                check("w_mem_single", 64'(prev_w), 64'(0));
                check("w_queue_nonempty", 64'(w_q.size() != 0), 64'(1));
                if (w_q.size() != 0) check("w_mem_addr_data", {mem_addr, data_if}, w_q.pop_front());
            end
            prev_w = w_mem;
            if (clk_en) clk_en_cnt++;
            if (reset_pc) rst_pc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        step();
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (3) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) tx_q.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump();
        for (int a = 0; a < 32; a++) push_word(32'h0000_0100 + 32'(a));
        for (int k = 0; k < 32; k++) push_word(32'hC0DE_0000 + 32'(4 * k));
    endtask

    task automatic wait_dump(input string tag);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || state != ST_IDLE) && n < 4000) begin
            step();
            n++;
        end
        check(tag, 64'(n < 4000), 64'(1));
    endtask

    task automatic wait_tx(input int target);
        int n;
        n = 0;
        while (tx_cnt < target && n < 2000) begin
            step();
            n++;
        end
        check("wait_tx_bound", 64'(n < 2000), 64'(1));
    endtask

    initial begin
        int t0;
        int c0;
        int w0;
        int r0;
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        halt     = 1'b0;
        #3;
        check("rst_state", 64'(state), 64'(ST_IDLE));
        check("rst_outs", 64'({clk_en, reset_pc, w_mem, tx_valid}), 64'(0));
        check("rst_regs", 64'({mem_addr, data_if}), 64'(0));
        check("rst_addrs", 64'({rd_addr, rd_addr_data}), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Program load of two words
        c0 = clk_en_cnt;
        w_q.push_back({32'h0, 32'h1122_3344});
        w_q.push_back({32'h4, 32'hAABB_CCDD});
        send_byte(CMD_LOAD);
        send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        check("load_writes", 64'(w_cnt), 64'(2));
        check("load_queue_empty", 64'(w_q.size()), 64'(0));
        check("load_no_clk_en", 64'(clk_en_cnt - c0), 64'(0));
        check("load_idle", 64'(state), 64'(ST_IDLE));

        // Single step then dump
        c0 = clk_en_cnt; t0 = tx_cnt;
        push_dump();
        send_byte(CMD_STEP);
        wait_dump("step_dump_done");
        check("step_clk_en", 64'(clk_en_cnt - c0), 64'(1));
        check("step_dump_len", 64'(tx_cnt - t0), 64'(256));

        // Continuous run, halt raised 10 cycles after clk_en rises
        c0 = clk_en_cnt; t0 = tx_cnt;
        push_dump();
        step();
        rx_data  = CMD_RUN;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (9) step();
        halt = 1'b1;
        wait_dump("run_dump_done");
        check("run_clk_en", 64'(clk_en_cnt - c0), 64'(10));
        check("run_dump_len", 64'(tx_cnt - t0), 64'(256));

        // Run while already halted
        c0 = clk_en_cnt; t0 = tx_cnt;
        push_dump();
        send_byte(CMD_RUN);
        wait_dump("halted_dump_done");
        check("halted_clk_en", 64'(clk_en_cnt - c0), 64'(0));
        check("halted_dump_len", 64'(tx_cnt - t0), 64'(256));
        halt = 1'b0;

        // Backpressure mid-dump, plus an RX command that must be dropped
        r0 = rst_pc_cnt; t0 = tx_cnt;
        push_dump();
        send_byte(CMD_STEP);
        wait_tx(t0 + 21);
        tx_ready = 1'b0;
        repeat (5) step();
        tx_ready = 1'b1;
        send_byte(CMD_RST_PC);
        wait_dump("bp_dump_done");
        check("bp_dump_len", 64'(tx_cnt - t0), 64'(256));
        check("rx_dropped_in_dump", 64'(rst_pc_cnt - r0), 64'(0));

        // PC reset pulse, unknown byte, zero-length load
        r0 = rst_pc_cnt; w0 = w_cnt; c0 = clk_en_cnt; t0 = tx_cnt;
        send_byte(CMD_RST_PC);
        check("rst_pc_pulse", 64'(rst_pc_cnt - r0), 64'(1));
        send_byte(8'h7F);
        check("unknown_idle", 64'(state), 64'(ST_IDLE));
        send_byte(CMD_LOAD);
        check("load_len_state", 64'(state), 64'(ST_LOAD_LEN));
        send_byte(8'h00);
        check("zero_load_idle", 64'(state), 64'(ST_IDLE));
        check("quiet_outputs", 64'({32'(w_cnt - w0), 32'(clk_en_cnt - c0 + tx_cnt - t0 + rst_pc_cnt - r0 - 1)}), 64'(0));

        // Reset during run
        send_byte(CMD_RUN);
        check("run_entered", 64'({state, clk_en}), 64'({ST_RUN, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("rst_run_outs", 64'({clk_en, tx_valid}), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        check("rst_run_idle", 64'({state, clk_en}), 64'({ST_IDLE, 1'b0}));

        // Reset during dump: nothing resent afterwards
        t0 = tx_cnt;
        push_dump();
        send_byte(CMD_STEP);
        wait_tx(t0 + 10);
        rst_n = 1'b0;
        #1;
        check("rst_dump_outs", 64'({clk_en, tx_valid}), 64'(0));
        tx_q.delete();
        step();
        rst_n = 1'b1;
        t0 = tx_cnt;
        repeat (20) step();
        check("rst_dump_idle", 64'({state, tx_valid}), 64'({ST_IDLE, 1'b0}));
        check("rst_dump_no_resend", 64'(tx_cnt - t0), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
